// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_gen2 register file: FSM states and the
// power-up contents table written during initialisation.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int INIT_TBL_N = 16;

  // Raw 16-bit table; callers zero-extend or truncate to their data width.
  function automatic logic [15:0] INIT_VAL(input int unsigned i);
    case (i)
      1:       return 16'hFFFF;
      2:       return 16'h0050;
      3:       return 16'hF033;
      4:       return 16'hF0FF;
      5:       return 16'h0040;
      6:       return 16'h6666;
      7:       return 16'h00FF;
      8:       return 16'h8888;
      12:      return 16'hCCCC;
      13:      return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set by issue, cleared by writes, set wins.
// Updates only while en is high; reads present the registered bits.
module regfile_scoreboard #(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          set,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_a,
  input  logic [AW-1:0] clr_a_addr,
  input  logic          clr_b,
  input  logic [AW-1:0] clr_b_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          pend1,
  output logic          pend2
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;

  always_comb begin
    pend_nxt = pend;
    if (en) begin
      if (clr_a) pend_nxt[clr_a_addr] = 1'b0;
      if (clr_b) pend_nxt[clr_b_addr] = 1'b0;
      // Applied last so a same-cycle set overrides either clear.
      if (set)   pend_nxt[set_addr]   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  assign pend1 = pend[rd_addr1];
  assign pend2 = pend[rd_addr2];

endmodule

// File: rtl/regfile_gen2.sv
// Two-read, two-write register file with a self-initialising INIT phase,
// optional write-to-read forwarding and a per-register pending scoreboard.
module regfile_gen2 import regfile_pkg::*; #(
  parameter  int NREGS    = 16,
  parameter  int DATA_W   = 16,
  parameter  int SPEC_IDX = 0,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              wrSpec,
  input  logic [DATA_W-1:0] wrDataSpec,
  input  logic [AW-1:0]     rdAddr1,
  output logic [DATA_W-1:0] rdData1,
  input  logic [AW-1:0]     rdAddr2,
  output logic [DATA_W-1:0] rdData2,
  output logic [DATA_W-1:0] rdDataSpec,
  input  logic              issue,
  input  logic [AW-1:0]     issueAddr,
  output logic              rdPend1,
  output logic              rdPend2,
  output logic              ready
);

  localparam logic [AW-1:0] SPEC_A = AW'(SPEC_IDX);
  localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     init_cnt;
  logic [AW-1:0]     init_cnt_nxt;
  logic [DATA_W-1:0] init_word;
  logic              run;
  logic              fwd_en;
  logic [DATA_W-1:0] mem [NREGS];

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == INIT) begin
      // Counter parks on the last index rather than wrapping.
      if (init_cnt == LAST_A) state_nxt    = RUN;
      else                    init_cnt_nxt = init_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  assign run       = (state == RUN);
  assign ready     = run;
  assign fwd_en    = (BYPASS != 0) && run;
  assign init_word = DATA_W'(INIT_VAL(32'(init_cnt)));

  // Main port is written after the special port so it wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[init_cnt] <= init_word;
      end else begin
        if (wrSpec) mem[SPEC_A] <= wrDataSpec;
        if (wr)     mem[wrAddr] <= wrData;
      end
    end
  end

  function automatic logic [DATA_W-1:0] fwd(
    input logic [AW-1:0]     a,
    input logic [DATA_W-1:0] stored,
    input logic              en,
    input logic              w,
    input logic [AW-1:0]     wa,
    input logic [DATA_W-1:0] wd,
    input logic              ws,
    input logic [DATA_W-1:0] wsd
  );
    if (en && w && (wa == a))       return wd;
    else if (en && ws && (a == SPEC_A)) return wsd;
    else                            return stored;
  endfunction

  assign rdData1    = fwd(rdAddr1, mem[rdAddr1], fwd_en, wr, wrAddr, wrData, wrSpec, wrDataSpec);
  assign rdData2    = fwd(rdAddr2, mem[rdAddr2], fwd_en, wr, wrAddr, wrData, wrSpec, wrDataSpec);
  assign rdDataSpec = fwd(SPEC_A,  mem[SPEC_A],  fwd_en, wr, wrAddr, wrData, wrSpec, wrDataSpec);

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .en         (run),
    .set        (issue),
    .set_addr   (issueAddr),
    .clr_a      (wr),
    .clr_a_addr (wrAddr),
    .clr_b      (wrSpec),
    .clr_b_addr (SPEC_A),
    .rd_addr1   (rdAddr1),
    .rd_addr2   (rdAddr2),
    .pend1      (rdPend1),
    .pend2      (rdPend2)
  );

endmodule

// File: tb/tb_regfile_gen2.sv
// Bench for regfile_gen2: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_regfile_gen2;

  localparam int NREGS    = 16;
  localparam int DATA_W   = 16;
  localparam int AW       = 4;
  localparam int SPEC_IDX = 0;
  localparam int BYP      = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr;
  logic [AW-1:0]     wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrSpec;
  logic [DATA_W-1:0] wrDataSpec;
  logic [AW-1:0]     rdAddr1;
  logic [DATA_W-1:0] rdData1;
  logic [AW-1:0]     rdAddr2;
  logic [DATA_W-1:0] rdData2;
  logic [DATA_W-1:0] rdDataSpec;
  logic              issue;
  logic [AW-1:0]     issueAddr;
  logic              rdPend1;
  logic              rdPend2;
  logic              ready;

  always #5 clk = ~clk;

  regfile_gen2 #(
    .NREGS    (NREGS),
    .DATA_W   (DATA_W),
    .SPEC_IDX (SPEC_IDX),
    .BYPASS   (BYP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .wrSpec     (wrSpec),
    .wrDataSpec (wrDataSpec),
    .rdAddr1    (rdAddr1),
    .rdData1    (rdData1),
    .rdAddr2    (rdAddr2),
    .rdData2    (rdData2),
    .rdDataSpec (rdDataSpec),
    .issue      (issue),
    .issueAddr  (issueAddr),
    .rdPend1    (rdPend1),
    .rdPend2    (rdPend2),
    .ready      (ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [NREGS];
  bit                m_pend [NREGS];
  bit                m_run;
  int                m_cnt;
  bit                chk_en = 1'b0;

  function automatic logic [DATA_W-1:0] ref_init(input int i);
    case (i)
      1: return 16'hFFFF;  2: return 16'h0050;  3: return 16'hF033;
      4: return 16'hF0FF;  5: return 16'h0040;  6: return 16'h6666;
      7: return 16'h00FF;  8: return 16'h8888; 12: return 16'hCCCC;
      13: return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

  // Contents are only observable once ready, so the model loads the table
  // at reset and simply counts the NREGS initialisation cycles.
  task automatic model_update();
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < NREGS; i++) begin
        m_pend[i] = 1'b0;
        m_mem[i]  = ref_init(i);
      end
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == NREGS) m_run = 1'b1;
    end else begin
      if (wrSpec) m_mem[SPEC_IDX] = wrDataSpec;
      if (wr)     m_mem[wrAddr]   = wrData;
      if (wrSpec) m_pend[SPEC_IDX] = 1'b0;
      if (wr)     m_pend[wrAddr]   = 1'b0;
      if (issue)  m_pend[issueAddr] = 1'b1;
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input int a);
    if (BYP != 0 && m_run && wr && int'(wrAddr) == a)          return wrData;
    else if (BYP != 0 && m_run && wrSpec && a == SPEC_IDX)     return wrDataSpec;
    else                                                       return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, m_run);
      chk("rdPend1", rdPend1, m_pend[rdAddr1]);
      chk("rdPend2", rdPend2, m_pend[rdAddr2]);
      if (m_run) begin
        chk("rdData1", rdData1, exp_read(int'(rdAddr1)));
        chk("rdData2", rdData2, exp_read(int'(rdAddr2)));
        chk("rdDataSpec", rdDataSpec, exp_read(SPEC_IDX));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic idle();
    wr = 1'b0; wrSpec = 1'b0; issue = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; idle();
    wrAddr = '0; wrData = '0; wrDataSpec = '0;
    rdAddr1 = '0; rdAddr2 = '0; issueAddr = '0;
    tick();
    chk_en = 1'b1;

    // Init sequence
    #1 chk("reset_ready", ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      #1 chk("init_ready_low", ready, 1'b0);
      tick();
    end
    rdAddr1 = 4'd2; rdAddr2 = 4'd13;
    #1;
    chk("init_ready_high", ready, 1'b1);
    chk("init_reg2", rdData1, 16'h0050);
    chk("init_reg13", rdData2, 16'h0002);

    // Dual write
    wr = 1'b1; wrAddr = 4'd3; wrData = 16'h1234;
    wrSpec = 1'b1; wrDataSpec = 16'hABCD;
    tick(); idle();
    rdAddr1 = 4'd3;
    #1;
    chk("dual_reg3", rdData1, 16'h1234);
    chk("dual_spec", rdDataSpec, 16'hABCD);

    // Collision on the special register
    wr = 1'b1; wrAddr = 4'd0; wrData = 16'h1111;
    wrSpec = 1'b1; wrDataSpec = 16'h2222;
    tick(); idle();
    rdAddr1 = 4'd0;
    #1;
    chk("collide_reg0", rdData1, 16'h1111);
    chk("collide_spec", rdDataSpec, 16'h1111);

    // Same-cycle forwarding
    wr = 1'b1; wrAddr = 4'd5; wrData = 16'hBEEF; rdAddr1 = 4'd5;
    #1 chk("bypass_rd1", rdData1, (BYP != 0) ? 16'hBEEF : 16'h0040);
    tick(); idle();

    // Scoreboard
    issue = 1'b1; issueAddr = 4'd7; rdAddr1 = 4'd7;
    tick(); idle();
    #1 chk("pend_set", rdPend1, 1'b1);
    wr = 1'b1; wrAddr = 4'd7; wrData = 16'h0707; issue = 1'b1; issueAddr = 4'd7;
    tick(); idle();
    #1 chk("pend_set_wins", rdPend1, 1'b1);
    wr = 1'b1; wrAddr = 4'd7; wrData = 16'h0770;
    tick(); idle();
    #1 chk("pend_clear", rdPend1, 1'b0);

    // Reset mid-INIT, with writes and issues attempted during INIT
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (8) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wr = 1'b1; wrAddr = 4'd2; wrData = 16'hDEAD;
    wrSpec = 1'b1; wrDataSpec = 16'hBEEF;
    issue = 1'b1; issueAddr = 4'd2;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    idle();
    rdAddr1 = 4'd2; rdAddr2 = 4'd0;
    #1;
    chk("restart_len", n, 16);
    chk("init_wr_ignored", rdData1, 16'h0050);
    chk("init_wrspec_ignored", rdData2, 16'h0000);
    chk("init_issue_ignored", rdPend1, 1'b0);

    // Randomized traffic
    repeat (800) begin
      rst        = ($urandom_range(0, 249) == 0);
      wr         = 1'($urandom_range(0, 1));
      wrAddr     = AW'($urandom_range(0, NREGS - 1));
      wrData     = DATA_W'($urandom);
      wrSpec     = 1'($urandom_range(0, 1));
      wrDataSpec = DATA_W'($urandom);
      issue      = 1'($urandom_range(0, 1));
      issueAddr  = ($urandom_range(0, 3) == 0) ? wrAddr : AW'($urandom_range(0, NREGS - 1));
      rdAddr1    = ($urandom_range(0, 2) == 0) ? wrAddr : AW'($urandom_range(0, NREGS - 1));
      rdAddr2    = ($urandom_range(0, 3) == 0) ? AW'(SPEC_IDX) : AW'($urandom_range(0, NREGS - 1));
      tick();
    end
    rst = 1'b0; idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_gen2.md
REGFILE_GEN2 -- requirements
Module: regfile_gen2

Interface
REQ-001 The block SHALL have these parameters:
- NREGS, 16: register count, power of two, 2..256.
- DATA_W, 16: register width in bits.
- SPEC_IDX, 0: index of the special register targeted by the dedicated write port.
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.

REQ-002 AW SHALL be the derived local constant $clog2(NREGS).

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- wr  in  1  main write enable.
- wrAddr  in  AW  main write address.
- wrData  in  DATA_W  main write data.
- wrSpec  in  1  special-register write enable.
- wrDataSpec  in  DATA_W  special-register write data.
- rdAddr1  in  AW  read port 1 address.
- rdData1  out  DATA_W  read port 1 data.
- rdAddr2  in  AW  read port 2 address.
- rdData2  out  DATA_W  read port 2 data.
- rdDataSpec  out  DATA_W  continuous view of register SPEC_IDX.
- issue  in  1  marks register issueAddr as pending.
- issueAddr  in  AW  address of the register being marked pending.
- rdPend1  out  1  pending bit of rdAddr1.
- rdPend2  out  1  pending bit of rdAddr2.
- ready  out  1  high in RUN state.

Function
REQ-004 The FSM SHALL have exactly two states, INIT and RUN; INIT is entered on rst, and INIT moves to RUN after the cycle in which initCnt == NREGS-1.
REQ-005 In INIT, each cycle SHALL write the package init value INIT_VAL(initCnt) to register initCnt and then increment initCnt; initialisation completes in exactly NREGS cycles.
REQ-006 In INIT, wr, wrSpec and issue SHALL be ignored, and ready SHALL be 0.
REQ-007 In RUN, ready SHALL be 1, and initCnt SHALL hold its value.
REQ-008 In RUN with wr=1, register wrAddr SHALL be written with wrData at the clock edge.
REQ-009 In RUN with wrSpec=1, register SPEC_IDX SHALL be written with wrDataSpec at the clock edge.
REQ-010 When wr=1, wrSpec=1 and wrAddr==SPEC_IDX in the same cycle, wrData SHALL win and wrDataSpec SHALL be discarded.
REQ-011 Reads SHALL be combinational, with zero latency.
REQ-012 With BYPASS=1 in RUN, a read address equal to wrAddr with wr=1 SHALL return wrData.
REQ-013 Otherwise, with BYPASS=1 in RUN, a read address equal to SPEC_IDX with wrSpec=1 SHALL return wrDataSpec.
REQ-014 Otherwise, a read SHALL return the stored array value.
REQ-015 With BYPASS=0, reads SHALL always return the stored array value.
REQ-016 rdDataSpec SHALL follow the same forwarding rules as the read ports, applied to address SPEC_IDX.
REQ-017 The block SHALL hold one pending bit per register.
REQ-018 In RUN, issue=1 SHALL set pending[issueAddr].
REQ-019 In RUN, an accepted wr SHALL clear pending[wrAddr].
REQ-020 In RUN, an accepted wrSpec SHALL clear pending[SPEC_IDX].
REQ-021 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-022 rdPend1 and rdPend2 SHALL present the registered pending bits, with no forwarding.
REQ-023 Address arithmetic SHALL be unsigned AW-bit; initCnt SHALL NOT wrap past NREGS-1.

Reset
REQ-024 rst SHALL be sampled only at the rising edge of clk; asserting it has no asynchronous effect.
REQ-025 On rst, the block SHALL set state=INIT, initCnt=0, all pending bits=0, and ready=0 from the next edge.
REQ-026 rst asserted mid-INIT SHALL restart initialisation from initCnt=0, taking a full NREGS cycles.
REQ-027 rst asserted mid-RUN SHALL discard any simultaneous write or issue.
REQ-028 While the array is being initialised, the data outputs SHALL show array contents and are undefined until ready=1.

Structure
REQ-029 The shared package regfile_pkg SHALL hold:
- INIT_VAL(i), a 16-entry table:
  - 1: FFFF, 2: 0050, 3: F033, 4: F0FF, 5: 0040, 6: 6666, 7: 00FF, 8: 8888, 12: CCCC, 13: 0002.
  - All other entries, and every index >= 16: 0000.
  - Each entry is zero-extended or truncated to DATA_W.
- The FSM state enum {INIT, RUN}.
REQ-030 Pending-bit storage and update SHALL be implemented in the sub-module regfile_scoreboard.
REQ-031 The block SHALL contain no other sub-modules.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Init: rst for 1 cycle, then release → ready=0 for 16 cycles and 1 on the 17th; rdAddr1=2 → 0x0050; rdAddr2=13 → 0x0002.
- Dual write: wr, wrAddr=3, wrData=0x1234 with wrSpec, wrDataSpec=0xABCD → next cycle reg3=0x1234 and rdDataSpec=0xABCD.
- Collision: wr, wrAddr=0, wrData=0x1111 with wrSpec, wrDataSpec=0x2222 → reg0=0x1111.
- Bypass: wr, wrAddr=5, wrData=0xBEEF with rdAddr1=5 in the same cycle → rdData1=0xBEEF when BYPASS=1, 0x0040 when BYPASS=0.
- Scoreboard: issue, issueAddr=7 → rdPend1=1 (rdAddr1=7) next cycle; wr to 7 plus issue to 7 in the same cycle → stays 1; wr to 7 alone → 0.
- Reset mid-INIT: rst at initCnt=8 → ready asserts exactly 16 cycles after release; wr=1 during INIT leaves init values unchanged.
